// File: rtl/receive_pkg.sv
// Shared types for the UART receive path: RX FSM states and the byte type.
// The PARITY state is only reached when RECEIVE_PARITY_EN is defined.
package receive_pkg;
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} RX_STATE_TYPE;
   typedef logic [7:0] UART_BYTE_TYPE;

   // Even parity: the parity bit makes the total count of ones even.
   function automatic logic even_par(input UART_BYTE_TYPE b);
      return ^b;
   endfunction
endpackage

// File: rtl/receive_if.sv
// Serial pin plus received-byte/status bundle of the UART receiver.
interface receive_if;
   import receive_pkg::*;
   logic          UART_RX;
   UART_BYTE_TYPE data;
   logic          valid;
   logic          busy;
   logic          frame_err;
   logic          parity_err;

   modport slave  (input UART_RX, output data, valid, busy, frame_err, parity_err);
   modport master (output UART_RX, input data, valid, busy, frame_err, parity_err);
endinterface

// File: rtl/receive_sync_2ff.sv
// Two-flop synchronizer for an asynchronous input pin; reset value is a parameter.
module sync_2ff #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);
   logic meta;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta <= RST_VAL;
         q    <= RST_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end
endmodule

// File: rtl/receive.sv
// UART receiver, 8N1 by default; define RECEIVE_PARITY_EN for 8E1 framing
// (even parity bit between data and stop, parity_err active).
module receive
   import receive_pkg::*;
#(
   parameter int WTIME = 868
) (
   input  logic    CLK,
   input  logic    RESET,
   receive_if.slave rx
);
   localparam int CW = $clog2(WTIME);
   localparam logic [CW-1:0] HALF = CW'(WTIME / 2);
   localparam logic [CW-1:0] LAST = CW'(WTIME - 1);

   RX_STATE_TYPE  state;
   logic [CW-1:0] cnt;
   logic [2:0]    bit_cnt;
   UART_BYTE_TYPE shreg;
   UART_BYTE_TYPE data_q;
   logic          rx_s, rx_d, fall, tick;
   logic          valid_q, ferr_q, par_bad;

   sync_2ff #(.RST_VAL(1'b1)) u_sync (.clk(CLK), .rst(RESET), .d(rx.UART_RX), .q(rx_s));

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) rx_d <= 1'b1;
      else       rx_d <= rx_s;
   end

   assign fall = rx_d & ~rx_s;
   // Start is checked half a bit in; every later sample is one full bit apart.
   assign tick = (state == START) ? (cnt == HALF) : (cnt == LAST);

`ifdef RECEIVE_PARITY_EN
   logic perr_q;
   assign rx.parity_err = perr_q;
`else
   assign par_bad       = 1'b0;
   assign rx.parity_err = 1'b0;
`endif

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state   <= IDLE;
         cnt     <= '0;
         bit_cnt <= '0;
         shreg   <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
`ifdef RECEIVE_PARITY_EN
         par_bad <= 1'b0;
         perr_q  <= 1'b0;
`endif
      end else begin
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
`ifdef RECEIVE_PARITY_EN
         perr_q  <= 1'b0;
`endif
         cnt <= tick ? '0 : cnt + 1'b1;
         case (state)
            IDLE: begin
               cnt <= '0;
               if (fall) begin
                  state   <= START;
                  bit_cnt <= '0;
`ifdef RECEIVE_PARITY_EN
                  par_bad <= 1'b0;
`endif
               end
            end
            START: if (tick) state <= rx_s ? IDLE : DATA;
            DATA: if (tick) begin
               shreg   <= {rx_s, shreg[7:1]};
               bit_cnt <= bit_cnt + 3'd1;
`ifdef RECEIVE_PARITY_EN
               if (bit_cnt == 3'd7) state <= PARITY;
`else
               if (bit_cnt == 3'd7) state <= STOP;
`endif
            end
`ifdef RECEIVE_PARITY_EN
            PARITY: if (tick) begin
               par_bad <= rx_s ^ even_par(shreg);
               state   <= STOP;
            end
`endif
            STOP: if (tick) begin
               state <= IDLE;
               if (rx_s && !par_bad) data_q <= shreg;
               valid_q <= rx_s & ~par_bad;
               ferr_q  <= ~rx_s;
`ifdef RECEIVE_PARITY_EN
               perr_q  <= par_bad;
`endif
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign rx.data      = data_q;
   assign rx.valid     = valid_q;
   assign rx.frame_err = ferr_q;
   assign rx.busy      = (state != IDLE);
endmodule

// File: tb/tb_receive.sv
// Self-checking bench for the UART receiver: vector table, hand-written corner
// sequences and randomized frames checked against a frame-level model.
module tb_receive;
   localparam int W = 10;
`ifdef RECEIVE_PARITY_EN
   localparam int FB = 10;
`else
   localparam int FB = 9;
`endif
   // Cycles from driving the start edge to the visible result pulse.
   localparam int LAT  = 3 + W / 2 + FB * W + 1;
   localparam int HIST = 16384;

   typedef struct {
      int         cyc;
      logic       v, fe, pe;
      logic [7:0] d;
   } ev_t;

   typedef struct {
      logic [7:0] b;
      logic       stopb, pflip;
      logic       v, fe, pe;
      logic [7:0] d;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   tests = 0;
   int   fails = 0;
   ev_t  evq[$];
   vec_t tbl[$];
   logic busy_hist [0:HIST-1];

   receive_if rx_if ();
   receive #(.WTIME(W)) dut (.CLK(clk), .RESET(rst), .rx(rx_if.slave));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (cyc < HIST) busy_hist[cyc] = rx_if.busy;
      if (rx_if.valid || rx_if.frame_err || rx_if.parity_err)
         evq.push_back('{cyc, rx_if.valid, rx_if.frame_err, rx_if.parity_err, rx_if.data});
   end

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
      end
   endtask

   // Starts at a negedge and drives start, data LSB first, [parity], stop.
   task automatic send_frame(input logic [7:0] b, input logic stopb, input logic pflip,
                             output int n);
      n = cyc;
      rx_if.UART_RX = 1'b0;
      repeat (W) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx_if.UART_RX = b[i];
         repeat (W) @(negedge clk);
      end
`ifdef RECEIVE_PARITY_EN
      rx_if.UART_RX = (^b) ^ pflip;
      repeat (W) @(negedge clk);
`else
      if (pflip) rx_if.UART_RX = 1'b1;
`endif
      rx_if.UART_RX = stopb;
      repeat (W) @(negedge clk);
      rx_if.UART_RX = 1'b1;
   endtask

   task automatic expect_frame(input string nm, input int n, input logic v, input logic fe,
                               input logic pe, input logic [7:0] d);
      ev_t e;
      #1;
      chk({nm, " event count"}, evq.size(), 1);
      if (evq.size() > 0) begin
         e = evq.pop_front();
         chk({nm, " cycle"}, e.cyc, n + LAT);
         chk({nm, " valid"}, e.v, v);
         chk({nm, " frame_err"}, e.fe, fe);
         chk({nm, " parity_err"}, e.pe, pe);
      end
      chk({nm, " data"}, rx_if.data, d);
      evq.delete();
   endtask

   task automatic expect_none(input string nm);
      #1;
      chk({nm, " no event"}, evq.size(), 0);
      evq.delete();
   endtask

   function automatic logic bh(input int c);
      return (c >= 0 && c < HIST) ? busy_hist[c] : 1'bx;
   endfunction

   initial begin
      int         n, n2;
      logic [7:0] last_good;
      logic       prev_stop;
      rx_if.UART_RX = 1'b1;

      // Vector table: {byte, stop, parity flip, exp valid, exp ferr, exp perr, exp data}
      tbl.push_back('{8'h67, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h67});
      tbl.push_back('{8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h67});
      tbl.push_back('{8'h01, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h01});
      tbl.push_back('{8'h80, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h80});
      tbl.push_back('{8'h55, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h55});
`ifdef RECEIVE_PARITY_EN
      tbl.push_back('{8'hC7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h55});
      tbl.push_back('{8'h3A, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h55});
      tbl.push_back('{8'h96, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h96});
`endif

      repeat (3) @(negedge clk);
      chk("reset data", rx_if.data, 8'h00);
      chk("reset valid", rx_if.valid, 1'b0);
      chk("reset busy", rx_if.busy, 1'b0);
      chk("reset frame_err", rx_if.frame_err, 1'b0);
      chk("reset parity_err", rx_if.parity_err, 1'b0);
      rst = 1'b0;
      repeat (5) @(negedge clk);

      foreach (tbl[i]) begin
         send_frame(tbl[i].b, tbl[i].stopb, tbl[i].pflip, n);
         expect_frame($sformatf("vec%0d", i), n, tbl[i].v, tbl[i].fe, tbl[i].pe, tbl[i].d);
         chk($sformatf("vec%0d busy before", i), bh(n + 2), 1'b0);
         chk($sformatf("vec%0d busy at t0", i), bh(n + 3), 1'b1);
         chk($sformatf("vec%0d busy last", i), bh(n + LAT - 1), 1'b1);
         chk($sformatf("vec%0d busy after", i), bh(n + LAT), 1'b0);
         repeat (5) @(negedge clk);
      end
      last_good = tbl[tbl.size() - 1].d;

      // Start glitch: three cycles low, rejected at the half-bit sample.
      n = cyc;
      rx_if.UART_RX = 1'b0;
      repeat (3) @(negedge clk);
      rx_if.UART_RX = 1'b1;
      repeat (20) @(negedge clk);
      expect_none("glitch");
      chk("glitch busy start", bh(n + 3), 1'b1);
      chk("glitch busy at sample", bh(n + 3 + W / 2), 1'b1);
      chk("glitch busy drop", bh(n + 4 + W / 2), 1'b0);

      // Back-to-back frames with no idle gap.
      send_frame(8'h00, 1'b1, 1'b0, n);
      expect_frame("b2b first", n, 1'b1, 1'b0, 1'b0, 8'h00);
      send_frame(8'hFF, 1'b1, 1'b0, n2);
      expect_frame("b2b second", n2, 1'b1, 1'b0, 1'b0, 8'hFF);
      last_good = 8'hFF;
      repeat (5) @(negedge clk);

      // Break after a frame error: no re-arm until the line returns high.
      send_frame(8'hA5, 1'b0, 1'b0, n);
      rx_if.UART_RX = 1'b0;
      expect_frame("break ferr", n, 1'b0, 1'b1, 1'b0, last_good);
      repeat (40) @(negedge clk);
      expect_none("break held");
      chk("break busy", rx_if.busy, 1'b0);
      rx_if.UART_RX = 1'b1;
      repeat (20) @(negedge clk);
      expect_none("break release");

      // Reset during data bit 4, then a clean frame.
      rx_if.UART_RX = 1'b0;
      repeat (W) @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         rx_if.UART_RX = (8'hC3 >> i) & 8'h01;
         repeat (i == 4 ? 3 : W) @(negedge clk);
      end
      rst = 1'b1;
      @(negedge clk);
      chk("midreset data", rx_if.data, 8'h00);
      chk("midreset busy", rx_if.busy, 1'b0);
      chk("midreset valid", rx_if.valid, 1'b0);
      chk("midreset frame_err", rx_if.frame_err, 1'b0);
      rx_if.UART_RX = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (150) @(negedge clk);
      expect_none("after reset");
      send_frame(8'h3C, 1'b1, 1'b0, n);
      expect_frame("post reset", n, 1'b1, 1'b0, 1'b0, 8'h3C);
      last_good = 8'h3C;

      // Randomized frames against the frame-level model.
      prev_stop = 1'b1;
      for (int k = 0; k < 24; k++) begin
         logic [7:0] b;
         logic       sb, pf, pbad;
         int         gap;
         b   = 8'($urandom);
         sb  = ($urandom_range(0, 3) != 0);
`ifdef RECEIVE_PARITY_EN
         pf  = ($urandom_range(0, 3) == 0);
`else
         pf  = 1'b0;
`endif
         pbad = pf;
         gap  = prev_stop ? $urandom_range(0, 8) : $urandom_range(1, 8);
         repeat (gap) @(negedge clk);
         send_frame(b, sb, pf, n);
         if (sb && !pbad) last_good = b;
         expect_frame($sformatf("rnd%0d", k), n, sb & ~pbad, ~sb, pbad, last_good);
         prev_stop = sb;
      end

      repeat (20) @(negedge clk);
      expect_none("final idle");
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
